uart_rx_deframer: RTL and testbench
===================================

Name: uart_rx_deframer

Overview:
- Receive-side serial deframer for the team's 16550-compatible UART.
- Sits directly upstream of the receiver FIFO, which is 16 deep and 11 bits wide.
- Synchronises the serial input and generates the 16x oversampling tick from the divisor latch.
- Decodes start, data, parity and stop bits per the Line Control register, then pushes one 11-bit word per character: 8 data bits plus break, parity and framing flags.

Parameters:
- REC_WIDTH, 11, width of the pushed word; fixed layout described below.
- DIV_W, 16, width of the divisor latch (DL2:DL1).
- SYNC_STAGES, 2, flip-flop stages on srx_i; minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- srx_i  in  1  serial receive line; idle high
- dl_i  in  DIV_W  divisor latch value; 16x tick period in clk cycles
- lc_i  in  8  Line Control: [1:0] char bits (00=5 … 11=8), [2] SB, [3] PE, [4] EP, [5] SP; [7:6] ignored
- fifo_full_i  in  1  RX FIFO full
- fifo_empty_i  in  1  RX FIFO empty (used by the timeout logic)
- fifo_rd_i  in  1  RX FIFO pop strobe (used by the timeout logic)
- push_o  out  1  one-cycle write strobe to the RX FIFO
- data_o  out  REC_WIDTH  [7:0] data (zero-extended for short chars), [8] FE, [9] PE, [10] BI
- overrun_o  out  1  one-cycle pulse: character completed while fifo_full_i=1
- rx_busy_o  out  1  high whenever the FSM is not IDLE
- timeout_o  out  1  character timeout indication (see Optional Feature)

Behaviour:
- Reset values:
  - all outputs 0; data_o = 0.
  - synchroniser flops reset to 1 (line idle), so no false start is seen at reset release.
  - FSM = IDLE; tick counter = 0.
- Tick generator:
  - Down-counter reloads to dl_i-1; tick asserted for one clk when the counter is 0.
  - dl_i=0: no ticks; FSM held in IDLE.
  - Any change of dl_i (compared against a registered copy) reloads the counter next cycle.
  - A frame in progress continues at the new rate.
- All FSM advances happen on tick cycles only. Sample counter is 4 bits, 0..15.
- IDLE:
  - Synchronised srx low on a tick → START, sample counter cleared.
- START:
  - At count 7 (mid-bit), srx high → false start, return to IDLE with no push.
  - At count 7, srx low → continue; at count 15 → DATA.
- DATA:
  - Sample at count 7, shift LSB-first.
  - After N = 5 + lc_i[1:0] bits → PARITY if PE=1, else STOP.
- PARITY:
  - Expected bit by {SP,EP}: 00 = odd, 01 = even, 10 = forced 1, 11 = forced 0.
  - Mismatch sets PE.
- STOP:
  - Only the first stop bit is sampled; SB is used by the timeout length only.
  - Sampled 0 → FE=1.
  - Break: all data bits, parity (if enabled) and stop sampled 0 → BI=1, FE=1, data=0.
  - The cycle after the mid-stop tick: push_o=1 if fifo_full_i=0, otherwise overrun_o=1 and the word is dropped.
  - Then → IDLE if srx high, or → WAIT_IDLE if srx low.
- WAIT_IDLE:
  - Stays until synchronised srx is sampled high on a tick, then → IDLE.
  - Guarantees one break produces exactly one push.
- lc_i is captured at the START→DATA transition; changes mid-frame do not affect the current character.
- Latency: push_o is 1 clk after the mid-stop tick.
- data_o holds its value until the next push.
- rst asserted mid-frame: immediate return to IDLE; no push.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- Defined:
  - A 10-bit tick counter measures character time: 16 × (1 start + N data + PE + (SB ? 2 : 1)) ticks.
  - The counter clears on push_o, on fifo_rd_i, or while fifo_empty_i=1; otherwise it counts ticks.
  - timeout_o rises when the count reaches 4 character times.
  - timeout_o stays high until the next push_o or fifo_rd_i.
- Undefined:
  - timeout_o is tied to 0 and no counter is synthesised.

Test Plan:
- 8N1 framing: dl_i=3, lc_i=8'h03, send 0xA5 at 48 clk/bit → exactly one push_o, data_o=11'h0A5, overrun_o=0, push 1 clk after the mid-stop tick.
- Parity error: 7E1 (lc_i=8'h1A), send 0x35 with parity bit 1 → data_o=11'h235 (PE set).
- Forced-parity pass: lc_i=8'h3A, send 0x35 with parity 0 → data_o=11'h035.
- Break: dl_i=3, srx_i low for 15 bit-times → exactly one push with data_o=11'h500 (BI and FE); no further push until srx high; then 0x55 is received normally as 11'h055.
- False start and overrun:
  - 5-tick low glitch → no push, rx_busy_o returns 0.
  - 0x3C received with fifo_full_i=1 → overrun_o one-cycle pulse, push_o stays 0.
- Timeout (macro defined): 8N1, one char pushed, fifo_empty_i=0, no reads → timeout_o=1 exactly 4×160=640 ticks after push; fifo_rd_i pulse clears it next cycle.
- Timeout (macro undefined): same stimulus → timeout_o stays 0.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// ============================================================================
// Module   : uart_rx_deframer
// Purpose  : 16x-oversampled UART receive deframer feeding an 11-bit RX FIFO.
//            Optional character timeout enabled by macro UART_RX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_deframer #(
  parameter int REC_WIDTH   = 11,
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 srx_i,
  input  logic [DIV_W-1:0]     dl_i,
  input  logic [7:0]           lc_i,
  input  logic                 fifo_full_i,
  input  logic                 fifo_empty_i,
  input  logic                 fifo_rd_i,
  output logic                 push_o,
  output logic [REC_WIDTH-1:0] data_o,
  output logic                 overrun_o,
  output logic                 rx_busy_o,
  output logic                 timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DIV_W-1:0]       dl_q, dl_d;
  logic [DIV_W-1:0]       tcnt_q, tcnt_d;
  state_t                 state_q, state_d;
  logic [3:0]             scnt_q, scnt_d;
  logic [2:0]             bcnt_q, bcnt_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   ones_q, ones_d;
  logic                   pe_q, pe_d;
  logic [1:0]             nsel_q, nsel_d;
  logic                   pen_q, pen_d;
  logic                   ep_q, ep_d;
  logic                   sp_q, sp_d;
  logic                   push_q, push_d;
  logic                   ovr_q, ovr_d;
  logic [REC_WIDTH-1:0]   data_q, data_d;

  logic       srx_s;
  logic       div_en;
  logic       dl_chg;
  logic       tick;
  logic       last_bit;
  logic       par_exp;
  logic       fe;
  logic       bi;
  logic [3:0] scnt_inc;
  logic [10:0] word;

  assign srx_s  = sync_q[SYNC_STAGES-1];
  assign div_en = (dl_q != '0);
  assign dl_chg = (dl_i != dl_q);
  // A divisor change suppresses the tick for the reload cycle.
  assign tick   = div_en && !dl_chg && (tcnt_q == '0);

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], srx_i};
    dl_d   = dl_i;
    tcnt_d = tcnt_q;
    if (dl_chg) begin
      tcnt_d = (dl_i == '0) ? '0 : dl_i - DIV_W'(1);
    end else if (!div_en) begin
      tcnt_d = '0;
    end else if (tcnt_q == '0) begin
      tcnt_d = dl_q - DIV_W'(1);
    end else begin
      tcnt_d = tcnt_q - DIV_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    bcnt_d   = bcnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    ones_d   = ones_q;
    pe_d     = pe_q;
    nsel_d   = nsel_q;
    pen_d    = pen_q;
    ep_d     = ep_q;
    sp_d     = sp_q;
    push_d   = 1'b0;
    ovr_d    = 1'b0;
    data_d   = data_q;
    scnt_inc = scnt_q + 4'd1;
    last_bit = (bcnt_q == (3'd4 + {1'b0, nsel_q}));
    fe       = !srx_s;
    bi       = !srx_s && !ones_q;
    word     = {bi, pe_q, fe, shreg_q};

    case ({sp_q, ep_q})
      2'b00:   par_exp = ~par_q;
      2'b01:   par_exp = par_q;
      2'b10:   par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase

    if (!div_en) begin
      state_d = S_IDLE;
    end else if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!srx_s) begin
            state_d = S_START;
            scnt_d  = 4'd0;
          end
        end
        S_START: begin
          if (scnt_q == 4'd7 && srx_s) begin
            state_d = S_IDLE;
          end else if (scnt_q == 4'd15) begin
            // Line format is frozen here for the rest of the character.
            state_d = S_DATA;
            scnt_d  = 4'd0;
            bcnt_d  = 3'd0;
            shreg_d = 8'd0;
            par_d   = 1'b0;
            ones_d  = 1'b0;
            pe_d    = 1'b0;
            nsel_d  = lc_i[1:0];
            pen_d   = lc_i[3];
            ep_d    = lc_i[4];
            sp_d    = lc_i[5];
          end else begin
            scnt_d = scnt_inc;
          end
        end
        S_DATA: begin
          scnt_d = scnt_inc;
          if (scnt_q == 4'd7) begin
            shreg_d[bcnt_q] = srx_s;
            par_d           = par_q ^ srx_s;
            ones_d          = ones_q | srx_s;
          end
          if (scnt_q == 4'd15) begin
            if (last_bit) begin
              state_d = pen_q ? S_PARITY : S_STOP;
            end else begin
              bcnt_d = bcnt_q + 3'd1;
            end
          end
        end
        S_PARITY: begin
          scnt_d = scnt_inc;
          if (scnt_q == 4'd7) begin
            pe_d   = (srx_s != par_exp);
            ones_d = ones_q | srx_s;
          end
          if (scnt_q == 4'd15) begin
            state_d = S_STOP;
          end
        end
        S_STOP: begin
          scnt_d = scnt_inc;
          if (scnt_q == 4'd7) begin
            if (fifo_full_i) begin
              ovr_d = 1'b1;
            end else begin
              push_d = 1'b1;
              data_d = REC_WIDTH'(word);
            end
            // A low stop bit parks in WAIT_IDLE so a break yields one push.
            state_d = srx_s ? S_IDLE : S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (srx_s) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '1;
      dl_q    <= '0;
      tcnt_q  <= '0;
      state_q <= S_IDLE;
      scnt_q  <= 4'd0;
      bcnt_q  <= 3'd0;
      shreg_q <= 8'd0;
      par_q   <= 1'b0;
      ones_q  <= 1'b0;
      pe_q    <= 1'b0;
      nsel_q  <= 2'd0;
      pen_q   <= 1'b0;
      ep_q    <= 1'b0;
      sp_q    <= 1'b0;
      push_q  <= 1'b0;
      ovr_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      dl_q    <= dl_d;
      tcnt_q  <= tcnt_d;
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      ones_q  <= ones_d;
      pe_q    <= pe_d;
      nsel_q  <= nsel_d;
      pen_q   <= pen_d;
      ep_q    <= ep_d;
      sp_q    <= sp_d;
      push_q  <= push_d;
      ovr_q   <= ovr_d;
      data_q  <= data_d;
    end
  end

  assign push_o    = push_q;
  assign overrun_o = ovr_q;
  assign data_o    = data_q;
  assign rx_busy_o = (state_q != S_IDLE);

`ifdef UART_RX_TIMEOUT_EN
  logic [9:0] tocnt_q, tocnt_d;
  logic       to_q, to_d;
  logic [3:0] char_bits;
  logic [9:0] to_limit;
  logic       unused_lc;

  assign unused_lc = ^lc_i[7:6];

  always_comb begin
    char_bits = 4'd6 + {2'b00, lc_i[1:0]} + {3'b000, lc_i[3]} + (lc_i[2] ? 4'd2 : 4'd1);
    // Four character times of 16 ticks each.
    to_limit  = {char_bits, 6'b000000};
    tocnt_d   = tocnt_q;
    to_d      = to_q;
    if (push_q || fifo_rd_i || fifo_empty_i) begin
      tocnt_d = 10'd0;
    end else if (tick && (tocnt_q < to_limit)) begin
      tocnt_d = tocnt_q + 10'd1;
    end
    if (push_q || fifo_rd_i) begin
      to_d = 1'b0;
    end else if (tocnt_q >= to_limit) begin
      to_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tocnt_q <= 10'd0;
      to_q    <= 1'b0;
    end else begin
      tocnt_q <= tocnt_d;
      to_q    <= to_d;
    end
  end

  assign timeout_o = to_q;
`else
  logic unused_to;

  assign unused_to = ^{lc_i[7:6], lc_i[2], fifo_empty_i, fifo_rd_i};
  assign timeout_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
// Directed self-checking bench for uart_rx_deframer (dl_i=3, 48 clk per bit).
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_deframer;
  localparam int BIT_CLK = 48;
`ifdef UART_RX_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        srx_i;
  logic [15:0] dl_i;
  logic [7:0]  lc_i;
  logic        fifo_full_i;
  logic        fifo_empty_i;
  logic        fifo_rd_i;
  logic        push_o;
  logic [10:0] data_o;
  logic        overrun_o;
  logic        rx_busy_o;
  logic        timeout_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_push = 0;
  int n_ovr  = 0;
  int ovr_run = 0;
  int max_ovr = 0;
  int last_push_cyc = 0;
  logic [10:0] last_data = 11'h0;
  bit busy_seen = 1'b0;

  uart_rx_deframer #(.REC_WIDTH(11), .DIV_W(16), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .srx_i        (srx_i),
    .dl_i         (dl_i),
    .lc_i         (lc_i),
    .fifo_full_i  (fifo_full_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rd_i    (fifo_rd_i),
    .push_o       (push_o),
    .data_o       (data_o),
    .overrun_o    (overrun_o),
    .rx_busy_o    (rx_busy_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (push_o) begin
        n_push        = n_push + 1;
        last_data     = data_o;
        last_push_cyc = cyc;
      end
      if (overrun_o) begin
        n_ovr   = n_ovr + 1;
        ovr_run = ovr_run + 1;
        if (ovr_run > max_ovr) max_ovr = ovr_run;
      end else begin
        ovr_run = 0;
      end
      if (rx_busy_o) busy_seen = 1'b1;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen,
                            input bit pbit, output int t0);
    @(negedge clk);
    srx_i = 1'b0;
    t0 = cyc;
    wait_clk(BIT_CLK);
    for (int i = 0; i < nb; i++) begin
      srx_i = d[i];
      wait_clk(BIT_CLK);
    end
    if (pen) begin
      srx_i = pbit;
      wait_clk(BIT_CLK);
    end
    srx_i = 1'b1;
    wait_clk(2 * BIT_CLK);
  endtask

  task automatic test_reset;
    rst = 1'b1; srx_i = 1'b1; dl_i = 16'd3; lc_i = 8'h03;
    fifo_full_i = 1'b0; fifo_empty_i = 1'b1; fifo_rd_i = 1'b0;
    wait_clk(4);
    total++; if (push_o !== 1'b0) begin bad++; $display("FAIL reset_push: got %b want 0", push_o); end
    total++; if (data_o !== 11'h000) begin bad++; $display("FAIL reset_data: got %h want 000", data_o); end
    total++; if (overrun_o !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %b want 0", overrun_o); end
    total++; if (rx_busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", rx_busy_o); end
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
    rst = 1'b0;
    wait_clk(20);
    total++; if (rx_busy_o !== 1'b0) begin bad++; $display("FAIL post_reset_busy: got %b want 0", rx_busy_o); end
    total++; if (n_push !== 0) begin bad++; $display("FAIL post_reset_push: got %0d want 0", n_push); end
  endtask

  task automatic test_8n1;
    int p0, o0, t0, lat;
    lc_i = 8'h03; p0 = n_push; o0 = n_ovr;
    send_frame(8'hA5, 8, 1'b0, 1'b0, t0);
    lat = last_push_cyc - t0;
    total++; if (n_push - p0 !== 1) begin bad++; $display("FAIL 8n1_count: got %0d want 1", n_push - p0); end
    total++; if (last_data !== 11'h0A5) begin bad++; $display("FAIL 8n1_data: got %h want 0a5", last_data); end
    total++; if (n_ovr - o0 !== 0) begin bad++; $display("FAIL 8n1_ovr: got %0d want 0", n_ovr - o0); end
    total++; if (lat < 455 || lat > 465) begin bad++; $display("FAIL 8n1_latency: got %0d want 455..465", lat); end
  endtask

  task automatic test_parity_error;
    int p0, t0;
    lc_i = 8'h1A; p0 = n_push;
    send_frame(8'h35, 7, 1'b1, 1'b1, t0);
    total++; if (n_push - p0 !== 1) begin bad++; $display("FAIL par_err_count: got %0d want 1", n_push - p0); end
    total++; if (last_data !== 11'h235) begin bad++; $display("FAIL par_err_data: got %h want 235", last_data); end
  endtask

  task automatic test_forced_parity;
    int p0, t0;
    lc_i = 8'h3A; p0 = n_push;
    send_frame(8'h35, 7, 1'b1, 1'b0, t0);
    total++; if (n_push - p0 !== 1) begin bad++; $display("FAIL forced_par_count: got %0d want 1", n_push - p0); end
    total++; if (last_data !== 11'h035) begin bad++; $display("FAIL forced_par_data: got %h want 035", last_data); end
  endtask

  task automatic test_break;
    int p0, t0;
    lc_i = 8'h03; p0 = n_push;
    @(negedge clk);
    srx_i = 1'b0;
    wait_clk(15 * BIT_CLK);
    total++; if (n_push - p0 !== 1) begin bad++; $display("FAIL break_count: got %0d want 1", n_push - p0); end
    total++; if (last_data !== 11'h500) begin bad++; $display("FAIL break_data: got %h want 500", last_data); end
    total++; if (rx_busy_o !== 1'b1) begin bad++; $display("FAIL break_wait_busy: got %b want 1", rx_busy_o); end
    srx_i = 1'b1;
    wait_clk(2 * BIT_CLK);
    total++; if (n_push - p0 !== 1) begin bad++; $display("FAIL break_release_count: got %0d want 1", n_push - p0); end
    send_frame(8'h55, 8, 1'b0, 1'b0, t0);
    total++; if (n_push - p0 !== 2) begin bad++; $display("FAIL after_break_count: got %0d want 2", n_push - p0); end
    total++; if (last_data !== 11'h055) begin bad++; $display("FAIL after_break_data: got %h want 055", last_data); end
  endtask

  task automatic test_false_start;
    int p0;
    p0 = n_push; busy_seen = 1'b0;
    @(negedge clk);
    srx_i = 1'b0;
    wait_clk(15);
    srx_i = 1'b1;
    wait_clk(100);
    total++; if (busy_seen !== 1'b1) begin bad++; $display("FAIL glitch_busy_seen: got %b want 1", busy_seen); end
    total++; if (rx_busy_o !== 1'b0) begin bad++; $display("FAIL glitch_busy_end: got %b want 0", rx_busy_o); end
    total++; if (n_push - p0 !== 0) begin bad++; $display("FAIL glitch_push: got %0d want 0", n_push - p0); end
  endtask

  task automatic test_overrun;
    int p0, o0, t0;
    fifo_full_i = 1'b1; p0 = n_push; o0 = n_ovr; max_ovr = 0;
    send_frame(8'h3C, 8, 1'b0, 1'b0, t0);
    fifo_full_i = 1'b0;
    total++; if (n_ovr - o0 !== 1) begin bad++; $display("FAIL ovr_count: got %0d want 1", n_ovr - o0); end
    total++; if (max_ovr !== 1) begin bad++; $display("FAIL ovr_width: got %0d want 1", max_ovr); end
    total++; if (n_push - p0 !== 0) begin bad++; $display("FAIL ovr_push: got %0d want 0", n_push - p0); end
    total++; if (data_o !== 11'h055) begin bad++; $display("FAIL ovr_data_hold: got %h want 055", data_o); end
  endtask

  task automatic test_reset_mid_frame;
    int p0;
    p0 = n_push;
    @(negedge clk);
    srx_i = 1'b0;
    wait_clk(3 * BIT_CLK);
    total++; if (rx_busy_o !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b want 1", rx_busy_o); end
    rst = 1'b1; srx_i = 1'b1;
    wait_clk(1);
    total++; if (rx_busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy_during: got %b want 0", rx_busy_o); end
    rst = 1'b0;
    wait_clk(12 * BIT_CLK);
    total++; if (n_push - p0 !== 0) begin bad++; $display("FAIL midrst_push: got %0d want 0", n_push - p0); end
  endtask

  task automatic test_timeout;
    int p0, t0;
    lc_i = 8'h03; fifo_empty_i = 1'b0; p0 = n_push;
    send_frame(8'h5A, 8, 1'b0, 1'b0, t0);
    total++; if (n_push - p0 !== 1) begin bad++; $display("FAIL to_push: got %0d want 1", n_push - p0); end
    while (cyc < last_push_cyc + 1890) @(negedge clk);
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0", timeout_o); end
    while (cyc < last_push_cyc + 1950) @(negedge clk);
    total++; if (timeout_o !== TO_EN) begin bad++; $display("FAIL to_level: got %b want %b", timeout_o, TO_EN); end
    fifo_rd_i = 1'b1;
    wait_clk(1);
    fifo_rd_i = 1'b0;
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL to_clear: got %b want 0", timeout_o); end
    fifo_empty_i = 1'b1;
    wait_clk(10);
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity_error();
    test_forced_parity();
    test_break();
    test_false_start();
    test_overrun();
    test_reset_mid_frame();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
